if_fetch_stage: RTL and testbench
=================================

// Module: if_fetch_stage
// PURPOSE
//  Instruction-fetch stage: PC register, instruction-memory req/ready handshake and IF/ID pipeline register.
//  Consumes the load-use stall controls (PC write enable, IF/ID write enable) and the branch/jump redirect from ID/EX.
//  Sits between instruction memory and the ID stage. Inserts bubbles on memory wait and on flush.
//  Counts hazard-stall cycles for performance debug.
// PARAMETERS
//  PC_WIDTH     32       width of PC, target and memory address
//  INSTR_WIDTH  32       instruction width
//  RESET_PC     32'h0    PC value loaded on reset
//  NOP_INSTR    32'h0    encoding written into IF/ID on a bubble (sll $0,$0,0)
//  CNT_WIDTH    16       width of the stall-cycle counter
// PORTS
//  CLK               in   1            clock, all state on rising edge
//  RESET             in   1            synchronous, active-high reset
//  I_IF_PC_WRITE     in   1            0 = hazard stall: hold PC
//  I_IF_IFID_WRITE   in   1            0 = hazard stall: hold IF/ID
//  I_IF_FLUSH        in   1            branch/jump taken: redirect PC, squash IF/ID
//  I_IF_TARGET       in   PC_WIDTH     redirect address, valid with I_IF_FLUSH
//  I_IF_IMEM_READY   in   1            memory completes the request this cycle
//  I_IF_IMEM_RDATA   in   INSTR_WIDTH  instruction, valid when REQ && READY
//  O_IF_IMEM_REQ     out  1            fetch request
//  O_IF_IMEM_ADDR    out  PC_WIDTH     fetch address (= PC, or held during drain)
//  O_IFID_PC4        out  PC_WIDTH     PC+4 of the instruction in IF/ID
//  O_IFID_INSTR      out  INSTR_WIDTH  instruction in IF/ID
//  O_IFID_VALID      out  1            1 = real instruction, 0 = bubble
//  O_IF_STALL_CNT    out  CNT_WIDTH    saturating count of hazard-stall cycles
// BEHAVIOUR
//  Reset values: PC=RESET_PC, IFID_PC4=0, IFID_INSTR=NOP_INSTR, VALID=0, STALL_CNT=0, state=S_IDLE, REQ=0.
//  stall = !I_IF_PC_WRITE || !I_IF_IFID_WRITE. Both are treated as one stall condition.
//  accept = REQ && READY. REQ is a function of state: 0 in S_IDLE, 1 in S_FETCH and S_DRAIN.
//  Protocol: while REQ=1 and READY=0, ADDR stays constant. The request is never withdrawn before accept.
//  States: S_IDLE, S_FETCH, S_DRAIN.
//   S_IDLE: lasts one cycle after reset. -> S_FETCH. IF/ID is a bubble.
//     A flush here loads PC=TARGET.
//   S_FETCH, priority order (first match wins):
//    1) FLUSH && (accept || !REQ): data is discarded. PC<=TARGET. IF/ID<=bubble. Stay in S_FETCH.
//    2) FLUSH && !accept: save TARGET in the redirect register. IF/ID<=bubble. -> S_DRAIN.
//    3) stall: PC and IF/ID hold. Any accepted data is discarded and the same PC is refetched.
//    4) accept: PC<=PC+4. IF/ID<={PC+4, RDATA, VALID=1}.
//    5) !accept: PC holds. IF/ID<=bubble (VALID=0, INSTR=NOP_INSTR, PC4 unchanged).
//   S_DRAIN: ADDR = the old PC (the outstanding request). IF/ID is a bubble every cycle.
//     A new FLUSH overwrites the saved target.
//     On accept, data is discarded, PC<=saved target (or TARGET if FLUSH is asserted the same cycle). -> S_FETCH.
//  Flush overrides stall: redirect and squash happen even with PC_WRITE=0.
//  PC arithmetic: PC+4 is modulo 2^PC_WIDTH. 32'hFFFF_FFFC wraps to 0.
//  STALL_CNT: +1 in each cycle with stall=1 and RESET=0. Saturates at all-ones.
//  RESET in any state, including mid-transaction, returns to reset values next cycle. REQ is dropped.
//  Fetch-to-IF/ID latency is 1 cycle: data accepted in cycle n is visible on the O_IFID_* outputs in cycle n+1.
// TESTING
//  Reset, READY=1 constant -> REQ=0 for 1 cycle; then ADDR 0,4,8...; IFID_PC4=4,8,... with VALID=1.
//  Hold PC_WRITE=IFID_WRITE=0 for 2 cycles at PC=8 -> PC=8, IF/ID hold, STALL_CNT=2; then resume fetch at 8.
//  READY=0 for 3 cycles at PC=0x10 -> ADDR stays 0x10, VALID=0 for 3 cycles, then INSTR=RDATA, PC4=0x14.
//  FLUSH with TARGET=0x100, READY=1 -> next ADDR=0x100; one bubble with VALID=0.
//  FLUSH with TARGET=0x200 while READY=0 at PC=0x20 -> ADDR stays 0x20 until READY, data dropped, next ADDR=0x200.
//  FLUSH during a stall; counter preset to 0xFFFF; PC=0xFFFF_FFFC -> flush wins; counter stays 0xFFFF; PC wraps to 0.

Source files
------------

// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
//
// Instruction-fetch stage of the pipeline. Owns the PC register, drives the
// instruction-memory request/ready handshake and holds the IF/ID pipeline
// register handed to the decode stage. It obeys the load-use stall controls
// coming from the hazard unit and the branch/jump redirect from ID/EX, and
// it keeps a saturating count of hazard-stall cycles for performance debug.
//
// Ports
//   clk               clock, all state updates on the rising edge
//   reset             synchronous, active-high reset
//   i_if_pc_write     0 = hazard stall, hold the PC
//   i_if_ifid_write   0 = hazard stall, hold IF/ID
//   i_if_flush        branch/jump taken: redirect the PC and squash IF/ID
//   i_if_target       redirect address, qualified by i_if_flush
//   i_if_imem_ready   memory completes the outstanding request this cycle
//   i_if_imem_rdata   fetched instruction, valid when req && ready
//   o_if_imem_req     fetch request
//   o_if_imem_addr    fetch address (the PC; held while a request drains)
//   o_ifid_pc4        PC+4 of the instruction sitting in IF/ID
//   o_ifid_instr      instruction sitting in IF/ID
//   o_ifid_valid      1 = real instruction, 0 = bubble
//   o_if_stall_cnt    saturating count of hazard-stall cycles
//
// The memory handshake is a plain req/ready pair: once a request is raised
// its address must not move until ready is seen. A redirect that arrives
// while a request is still outstanding therefore cannot retarget the fetch
// immediately; the target is parked in a redirect register and the stage
// sits in S_DRAIN until the stale request completes, discarding its data.
// ---------------------------------------------------------------------------
module if_fetch_stage #(
  parameter int                     PC_WIDTH    = 32,
  parameter int                     INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = '0,
  parameter int                     CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_if_pc_write,
  input  logic                   i_if_ifid_write,
  input  logic                   i_if_flush,
  input  logic [PC_WIDTH-1:0]    i_if_target,
  input  logic                   i_if_imem_ready,
  input  logic [INSTR_WIDTH-1:0] i_if_imem_rdata,
  output logic                   o_if_imem_req,
  output logic [PC_WIDTH-1:0]    o_if_imem_addr,
  output logic [PC_WIDTH-1:0]    o_ifid_pc4,
  output logic [INSTR_WIDTH-1:0] o_ifid_instr,
  output logic                   o_ifid_valid,
  output logic [CNT_WIDTH-1:0]   o_if_stall_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t                 r_state;
  logic                   r_req;
  logic [PC_WIDTH-1:0]    r_pc;
  logic [PC_WIDTH-1:0]    r_redirect;
  logic [PC_WIDTH-1:0]    r_ifid_pc4;
  logic [INSTR_WIDTH-1:0] r_ifid_instr;
  logic                   r_ifid_valid;
  logic [CNT_WIDTH-1:0]   r_stall_cnt;

  // -------------------------------------------------------------------------
  // Combinational helpers
  // -------------------------------------------------------------------------
  logic                   w_stall;
  logic                   w_accept;
  logic                   w_cnt_sat;
  logic [PC_WIDTH-1:0]    w_pc_plus4;

  // Either hazard enable being low is treated as one and the same stall.
  assign w_stall    = !i_if_pc_write || !i_if_ifid_write;
  assign w_accept   = r_req && i_if_imem_ready;
  assign w_cnt_sat  = &r_stall_cnt;
  // Natural truncation gives the required modulo-2^PC_WIDTH wrap.
  assign w_pc_plus4 = r_pc + PC_WIDTH'(4);

  // -------------------------------------------------------------------------
  // Sequential logic: FSM, PC, redirect register, IF/ID and stall counter
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_req        <= 1'b0;
      r_pc         <= RESET_PC;
      r_redirect   <= '0;
      r_ifid_pc4   <= '0;
      r_ifid_instr <= NOP_INSTR;
      r_ifid_valid <= 1'b0;
      r_stall_cnt  <= '0;
    end else begin
      // Stall cycles are counted in every state, including during a flush.
      if (w_stall && !w_cnt_sat) begin
        r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
      end

      case (r_state)
        // One quiet cycle after reset before the first request goes out.
        S_IDLE: begin
          if (i_if_flush) begin
            r_pc <= i_if_target;
          end
          r_ifid_instr <= NOP_INSTR;
          r_ifid_valid <= 1'b0;
          r_state      <= S_FETCH;
          r_req        <= 1'b1;
        end

        S_FETCH: begin
          if (i_if_flush && (w_accept || !r_req)) begin
            // The fetched word belongs to the wrong path: drop it and
            // retarget right away, the handshake is free to move.
            r_pc         <= i_if_target;
            r_ifid_instr <= NOP_INSTR;
            r_ifid_valid <= 1'b0;
          end else if (i_if_flush) begin
            // Request still outstanding: its address must stay put, so park
            // the target until the memory lets go of the stale request.
            r_redirect   <= i_if_target;
            r_ifid_instr <= NOP_INSTR;
            r_ifid_valid <= 1'b0;
            r_state      <= S_DRAIN;
          end else if (w_stall) begin
            // Hold PC and IF/ID. A word accepted now is thrown away; the
            // unchanged PC simply fetches it again next cycle.
          end else if (w_accept) begin
            r_pc         <= w_pc_plus4;
            r_ifid_pc4   <= w_pc_plus4;
            r_ifid_instr <= i_if_imem_rdata;
            r_ifid_valid <= 1'b1;
          end else begin
            // Memory wait: bubble into decode, PC4 left as it was.
            r_ifid_instr <= NOP_INSTR;
            r_ifid_valid <= 1'b0;
          end
        end

        S_DRAIN: begin
          r_ifid_instr <= NOP_INSTR;
          r_ifid_valid <= 1'b0;
          if (w_accept) begin
            // Stale word discarded. A flush landing on this very cycle is
            // the newest redirect and takes precedence over the parked one.
            r_pc    <= i_if_flush ? i_if_target : r_redirect;
            r_state <= S_FETCH;
          end else if (i_if_flush) begin
            r_redirect <= i_if_target;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  // The PC is never advanced while a request drains, so it is the fetch
  // address in every state.
  assign o_if_imem_req  = r_req;
  assign o_if_imem_addr = r_pc;
  assign o_ifid_pc4     = r_ifid_pc4;
  assign o_ifid_instr   = r_ifid_instr;
  assign o_ifid_valid   = r_ifid_valid;
  assign o_if_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_if_fetch_stage.sv
// ---------------------------------------------------------------------------
// Testbench for if_fetch_stage. Directed scenarios walk through the
// documented fetch, stall, memory-wait, flush and drain cases; a random phase
// then compares every output against a cycle-level behavioural model.
// A second instance with a 4-bit counter shares all inputs so that counter
// saturation is reachable in a handful of cycles.
// ---------------------------------------------------------------------------
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'h0;
  localparam int M_IDLE  = 0;
  localparam int M_FETCH = 1;
  localparam int M_DRAIN = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        pcw;
  logic        ifidw;
  logic        flush;
  logic [31:0] target;
  logic        ready;
  logic [31:0] rdata;

  logic        req;
  logic [31:0] addr;
  logic [31:0] pc4;
  logic [31:0] instr;
  logic        valid;
  logic [15:0] cnt;

  logic        s_req;
  logic [31:0] s_addr;
  logic [31:0] s_pc4;
  logic [31:0] s_instr;
  logic        s_valid;
  logic [3:0]  s_cnt;

  always #5 clk = ~clk;

  if_fetch_stage dut (
    .clk             (clk),
    .reset           (reset),
    .i_if_pc_write   (pcw),
    .i_if_ifid_write (ifidw),
    .i_if_flush      (flush),
    .i_if_target     (target),
    .i_if_imem_ready (ready),
    .i_if_imem_rdata (rdata),
    .o_if_imem_req   (req),
    .o_if_imem_addr  (addr),
    .o_ifid_pc4      (pc4),
    .o_ifid_instr    (instr),
    .o_ifid_valid    (valid),
    .o_if_stall_cnt  (cnt)
  );

  if_fetch_stage #(.CNT_WIDTH(4)) u_sat (
    .clk             (clk),
    .reset           (reset),
    .i_if_pc_write   (pcw),
    .i_if_ifid_write (ifidw),
    .i_if_flush      (flush),
    .i_if_target     (target),
    .i_if_imem_ready (ready),
    .i_if_imem_rdata (rdata),
    .o_if_imem_req   (s_req),
    .o_if_imem_addr  (s_addr),
    .o_ifid_pc4      (s_pc4),
    .o_ifid_instr    (s_instr),
    .o_ifid_valid    (s_valid),
    .o_if_stall_cnt  (s_cnt)
  );

  // -------------------------------------------------------------------------
  // Reference model: what the stage should hold after each rising edge.
  // -------------------------------------------------------------------------
  int          m_mode;
  logic [31:0] m_pc;
  logic [31:0] m_pc4;
  logic [31:0] m_instr;
  logic [31:0] m_redir;
  logic        m_valid;
  int          m_cnt;     // unsaturated count of stall cycles

  int g_checks = 0;
  int g_errors = 0;
  int g_cycle  = 0;

  function automatic int sat(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  task automatic model_step();
    logic acc;
    if (reset) begin
      m_mode = M_IDLE; m_pc = 32'h0; m_pc4 = 32'h0; m_instr = NOP;
      m_valid = 1'b0; m_cnt = 0; m_redir = 32'h0;
    end else begin
      if (!pcw || !ifidw) m_cnt++;
      acc = (m_mode != M_IDLE) && ready;
      if (m_mode == M_IDLE) begin
        if (flush) m_pc = target;
        m_valid = 1'b0; m_instr = NOP;
        m_mode = M_FETCH;
      end else if (m_mode == M_FETCH) begin
        if (flush && acc) begin
          m_pc = target; m_valid = 1'b0; m_instr = NOP;
        end else if (flush) begin
          m_redir = target; m_valid = 1'b0; m_instr = NOP; m_mode = M_DRAIN;
        end else if (!pcw || !ifidw) begin
          // everything holds
        end else if (acc) begin
          m_pc = m_pc + 32'd4; m_pc4 = m_pc; m_instr = rdata; m_valid = 1'b1;
        end else begin
          m_valid = 1'b0; m_instr = NOP;
        end
      end else begin
        m_valid = 1'b0; m_instr = NOP;
        if (acc) begin
          m_pc = flush ? target : m_redir;
          m_mode = M_FETCH;
        end else if (flush) begin
          m_redir = target;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    g_cycle++;
    $display("cycle %0d: req=%b addr=%h ifid_pc4=%h instr=%h valid=%b stall_cnt=%0d",
             g_cycle, req, addr, pc4, instr, valid, cnt);
  endtask

  // -------------------------------------------------------------------------
  // Scenarios
  // -------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1; pcw = 1'b1; ifidw = 1'b1; flush = 1'b0;
    target = 32'h0; ready = 1'b1; rdata = 32'h0;
    tick(); tick();
    g_checks++; if (req !== 1'b0) begin g_errors++; $display("FAIL reset_req got %b want 0", req); end
    g_checks++; if (addr !== 32'h0) begin g_errors++; $display("FAIL reset_addr got %h want 0", addr); end
    g_checks++; if (pc4 !== 32'h0) begin g_errors++; $display("FAIL reset_pc4 got %h want 0", pc4); end
    g_checks++; if (instr !== NOP) begin g_errors++; $display("FAIL reset_instr got %h want %h", instr, NOP); end
    g_checks++; if (valid !== 1'b0) begin g_errors++; $display("FAIL reset_valid got %b want 0", valid); end
    g_checks++; if (cnt !== 16'h0) begin g_errors++; $display("FAIL reset_cnt got %0d want 0", cnt); end
    reset = 1'b0;
    // First cycle out of reset is the idle cycle: still no request.
    g_checks++; if (req !== 1'b0) begin g_errors++; $display("FAIL idle_req got %b want 0", req); end
    tick();
    g_checks++; if (req !== 1'b1) begin g_errors++; $display("FAIL first_req got %b want 1", req); end
    g_checks++; if (addr !== 32'h0) begin g_errors++; $display("FAIL first_addr got %h want 0", addr); end
  endtask

  task automatic test_sequential();
    logic [31:0] d;
    for (int k = 0; k < 2; k++) begin
      d = $urandom; rdata = d;
      tick();
      g_checks++; if (addr !== 32'((k + 1) * 4)) begin g_errors++; $display("FAIL seq_addr got %h want %h", addr, 32'((k + 1) * 4)); end
      g_checks++; if (pc4 !== 32'((k + 1) * 4)) begin g_errors++; $display("FAIL seq_pc4 got %h want %h", pc4, 32'((k + 1) * 4)); end
      g_checks++; if (instr !== d) begin g_errors++; $display("FAIL seq_instr got %h want %h", instr, d); end
      g_checks++; if (valid !== 1'b1) begin g_errors++; $display("FAIL seq_valid got %b want 1", valid); end
    end
  endtask

  task automatic test_stall();
    logic [31:0] d;
    logic [31:0] held;
    held = m_instr;
    pcw = 1'b0; ifidw = 1'b0;
    for (int k = 0; k < 2; k++) begin
      rdata = $urandom;
      tick();
      g_checks++; if (addr !== 32'h8) begin g_errors++; $display("FAIL stall_addr got %h want 8", addr); end
      g_checks++; if (pc4 !== 32'h8) begin g_errors++; $display("FAIL stall_pc4 got %h want 8", pc4); end
      g_checks++; if (instr !== held || valid !== 1'b1) begin g_errors++; $display("FAIL stall_ifid got %h/%b want %h/1", instr, valid, held); end
      g_checks++; if (cnt !== 16'(k + 1)) begin g_errors++; $display("FAIL stall_cnt got %0d want %0d", cnt, k + 1); end
    end
    pcw = 1'b1; ifidw = 1'b1;
    d = $urandom; rdata = d;
    tick();
    g_checks++; if (pc4 !== 32'hC || instr !== d) begin g_errors++; $display("FAIL resume_ifid got %h/%h want c/%h", pc4, instr, d); end
    g_checks++; if (cnt !== 16'd2) begin g_errors++; $display("FAIL resume_cnt got %0d want 2", cnt); end
    rdata = $urandom;
    tick();
    g_checks++; if (addr !== 32'h10) begin g_errors++; $display("FAIL resume_addr got %h want 10", addr); end
  endtask

  task automatic test_mem_wait();
    logic [31:0] d;
    ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rdata = $urandom;
      tick();
      g_checks++; if (addr !== 32'h10 || req !== 1'b1) begin g_errors++; $display("FAIL wait_addr got %h/%b want 10/1", addr, req); end
      g_checks++; if (valid !== 1'b0 || instr !== NOP) begin g_errors++; $display("FAIL wait_bubble got %b/%h want 0/%h", valid, instr, NOP); end
      g_checks++; if (pc4 !== 32'h10) begin g_errors++; $display("FAIL wait_pc4 got %h want 10", pc4); end
    end
    ready = 1'b1; d = $urandom; rdata = d;
    tick();
    g_checks++; if (instr !== d || valid !== 1'b1) begin g_errors++; $display("FAIL wait_done got %h/%b want %h/1", instr, valid, d); end
    g_checks++; if (pc4 !== 32'h14 || addr !== 32'h14) begin g_errors++; $display("FAIL wait_pc got %h/%h want 14/14", pc4, addr); end
  endtask

  task automatic test_flush();
    logic [31:0] d;
    flush = 1'b1; target = 32'h100; ready = 1'b1; rdata = $urandom;
    tick();
    g_checks++; if (addr !== 32'h100) begin g_errors++; $display("FAIL flush_addr got %h want 100", addr); end
    g_checks++; if (valid !== 1'b0 || instr !== NOP) begin g_errors++; $display("FAIL flush_bubble got %b/%h want 0/%h", valid, instr, NOP); end
    flush = 1'b0; d = $urandom; rdata = d;
    tick();
    g_checks++; if (pc4 !== 32'h104 || instr !== d || valid !== 1'b1) begin g_errors++; $display("FAIL flush_next got %h/%h/%b want 104/%h/1", pc4, instr, valid, d); end
    flush = 1'b1; target = 32'h20;
    tick();
    flush = 1'b0;
    g_checks++; if (addr !== 32'h20) begin g_errors++; $display("FAIL flush_to20 got %h want 20", addr); end
  endtask

  task automatic test_flush_drain();
    logic [31:0] d;
    ready = 1'b0; flush = 1'b1; target = 32'h200; rdata = $urandom;
    tick();
    flush = 1'b0;
    g_checks++; if (addr !== 32'h20 || req !== 1'b1 || valid !== 1'b0) begin g_errors++; $display("FAIL drain_enter got %h/%b/%b want 20/1/0", addr, req, valid); end
    for (int k = 0; k < 2; k++) begin
      tick();
      g_checks++; if (addr !== 32'h20 || valid !== 1'b0) begin g_errors++; $display("FAIL drain_hold got %h/%b want 20/0", addr, valid); end
    end
    ready = 1'b1; rdata = $urandom;
    tick();
    g_checks++; if (addr !== 32'h200) begin g_errors++; $display("FAIL drain_redirect got %h want 200", addr); end
    g_checks++; if (valid !== 1'b0 || pc4 !== 32'h104) begin g_errors++; $display("FAIL drain_drop got %b/%h want 0/104", valid, pc4); end
    d = $urandom; rdata = d;
    tick();
    g_checks++; if (pc4 !== 32'h204 || instr !== d || valid !== 1'b1) begin g_errors++; $display("FAIL drain_next got %h/%h/%b want 204/%h/1", pc4, instr, valid, d); end
    // A second flush while draining replaces the parked target.
    ready = 1'b0; flush = 1'b1; target = 32'h300;
    tick();
    target = 32'h400;
    tick();
    flush = 1'b0; ready = 1'b1;
    tick();
    g_checks++; if (addr !== 32'h400) begin g_errors++; $display("FAIL drain_overwrite got %h want 400", addr); end
  endtask

  task automatic test_wrap_saturate();
    logic [31:0] d;
    pcw = 1'b0; ifidw = 1'b0; ready = 1'b1; flush = 1'b0;
    for (int k = 0; k < 14; k++) begin
      rdata = $urandom;
      tick();
    end
    g_checks++; if (cnt !== 16'd16) begin g_errors++; $display("FAIL sat_cnt16 got %0d want 16", cnt); end
    g_checks++; if (s_cnt !== 4'hF) begin g_errors++; $display("FAIL sat_cnt4 got %0d want 15", s_cnt); end
    g_checks++; if (addr !== 32'h400) begin g_errors++; $display("FAIL sat_addr got %h want 400", addr); end
    // Flush while stalled: the redirect still happens.
    flush = 1'b1; target = 32'hFFFF_FFFC;
    tick();
    g_checks++; if (addr !== 32'hFFFF_FFFC || valid !== 1'b0) begin g_errors++; $display("FAIL flush_stall got %h/%b want fffffffc/0", addr, valid); end
    g_checks++; if (s_cnt !== 4'hF || cnt !== 16'd17) begin g_errors++; $display("FAIL flush_stall_cnt got %0d/%0d want 15/17", s_cnt, cnt); end
    flush = 1'b0; pcw = 1'b1; ifidw = 1'b1; d = $urandom; rdata = d;
    tick();
    g_checks++; if (addr !== 32'h0 || pc4 !== 32'h0) begin g_errors++; $display("FAIL wrap got %h/%h want 0/0", addr, pc4); end
    g_checks++; if (instr !== d || valid !== 1'b1) begin g_errors++; $display("FAIL wrap_instr got %h/%b want %h/1", instr, valid, d); end
  endtask

  task automatic test_reset_mid();
    ready = 1'b0; flush = 1'b1; target = 32'h500;
    tick();
    flush = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    g_checks++; if (req !== 1'b0 || addr !== 32'h0) begin g_errors++; $display("FAIL midreset_req got %b/%h want 0/0", req, addr); end
    g_checks++; if (valid !== 1'b0 || pc4 !== 32'h0 || instr !== NOP) begin g_errors++; $display("FAIL midreset_ifid got %b/%h/%h want 0/0/0", valid, pc4, instr); end
    g_checks++; if (cnt !== 16'h0 || s_cnt !== 4'h0) begin g_errors++; $display("FAIL midreset_cnt got %0d/%0d want 0/0", cnt, s_cnt); end
    ready = 1'b1;
    tick();
    g_checks++; if (req !== 1'b1 || addr !== 32'h0) begin g_errors++; $display("FAIL midreset_resume got %b/%h want 1/0", req, addr); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 500; k++) begin
      reset  = ($urandom_range(0, 99) < 2);
      pcw    = ($urandom_range(0, 99) < 85);
      ifidw  = ($urandom_range(0, 99) < 85);
      flush  = ($urandom_range(0, 99) < 10);
      target = $urandom & 32'hFFFF_FFFC;
      ready  = ($urandom_range(0, 99) < 60);
      rdata  = $urandom;
      tick();
      g_checks++; if (req !== (m_mode != M_IDLE)) begin g_errors++; $display("FAIL rnd_req cycle %0d got %b want %b", g_cycle, req, m_mode != M_IDLE); end
      g_checks++; if (addr !== m_pc) begin g_errors++; $display("FAIL rnd_addr cycle %0d got %h want %h", g_cycle, addr, m_pc); end
      g_checks++; if (pc4 !== m_pc4) begin g_errors++; $display("FAIL rnd_pc4 cycle %0d got %h want %h", g_cycle, pc4, m_pc4); end
      g_checks++; if (instr !== m_instr) begin g_errors++; $display("FAIL rnd_instr cycle %0d got %h want %h", g_cycle, instr, m_instr); end
      g_checks++; if (valid !== m_valid) begin g_errors++; $display("FAIL rnd_valid cycle %0d got %b want %b", g_cycle, valid, m_valid); end
      g_checks++; if (cnt !== 16'(sat(m_cnt, 65535))) begin g_errors++; $display("FAIL rnd_cnt cycle %0d got %0d want %0d", g_cycle, cnt, sat(m_cnt, 65535)); end
      g_checks++; if (s_cnt !== 4'(sat(m_cnt, 15))) begin g_errors++; $display("FAIL rnd_cnt4 cycle %0d got %0d want %0d", g_cycle, s_cnt, sat(m_cnt, 15)); end
      g_checks++; if (s_req !== req || s_addr !== m_pc || s_pc4 !== m_pc4 || s_instr !== m_instr || s_valid !== m_valid) begin
        g_errors++; $display("FAIL rnd_small cycle %0d got %b/%h/%h/%h/%b want %b/%h/%h/%h/%b", g_cycle,
                             s_req, s_addr, s_pc4, s_instr, s_valid, m_mode != M_IDLE, m_pc, m_pc4, m_instr, m_valid);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    m_mode = M_IDLE; m_pc = 32'h0; m_pc4 = 32'h0; m_instr = NOP;
    m_valid = 1'b0; m_cnt = 0; m_redir = 32'h0;
    test_reset();
    test_sequential();
    test_stall();
    test_mem_wait();
    test_flush();
    test_flush_drain();
    test_wrap_saturate();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", g_checks, g_errors);
    $finish;
  end

endmodule
